jtag_tap_driver: RTL and testbench

// Host-side JTAG initiator: drives TCK/TMS/TDI into a target TAP and its boundary-scan chain, samples TDO.

---
 rtl/jtag_pkg.sv | 31 +++
 rtl/jtag_tap_driver_if.sv | 34 +++
 rtl/jtag_tap_tracker.sv | 47 ++++
 rtl/jtag_tap_driver.sv | 189 ++++++++++++++++++
 tb/tb_jtag_tap_driver.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_pkg.sv
// Shared encodings for the JTAG host driver: IEEE 1149.1 TAP states,
// controller states and the length of the TAP reset sequence.
package jtag_pkg;

  localparam logic [3:0] TAP_EXIT2_DR  = 4'h0;
  localparam logic [3:0] TAP_EXIT1_DR  = 4'h1;
  localparam logic [3:0] TAP_SHIFT_DR  = 4'h2;
  localparam logic [3:0] TAP_PAUSE_DR  = 4'h3;
  localparam logic [3:0] TAP_SEL_IR    = 4'h4;
  localparam logic [3:0] TAP_UPD_DR    = 4'h5;
  localparam logic [3:0] TAP_CAP_DR    = 4'h6;
  localparam logic [3:0] TAP_SEL_DR    = 4'h7;
  localparam logic [3:0] TAP_EXIT2_IR  = 4'h8;
  localparam logic [3:0] TAP_EXIT1_IR  = 4'h9;
  localparam logic [3:0] TAP_SHIFT_IR  = 4'hA;
  localparam logic [3:0] TAP_PAUSE_IR  = 4'hB;
  localparam logic [3:0] TAP_RTI       = 4'hC;
  localparam logic [3:0] TAP_UPD_IR    = 4'hD;
  localparam logic [3:0] TAP_CAP_IR    = 4'hE;
  localparam logic [3:0] TAP_TLR       = 4'hF;

  typedef enum logic [1:0] {
    C_RST_SEQ,
    C_IDLE,
    C_SCAN,
    C_FINISH
  } ctl_e;

  localparam int RST_SEQ_LEN = 6;

endpackage

// File: rtl/jtag_tap_driver_if.sv
// Request/response and JTAG pin bundle of the host driver.
// slave: the driver itself; master: the requester plus the target's TDO.
interface jtag_tap_driver_if #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);

  logic               Start;
  logic               IsIR;
  logic [LEN_W-1:0]   Length;
  logic [MAX_LEN-1:0] DataIn;
  logic               TDO;
  logic               TCK;
  logic               TMS;
  logic               TDI;
  logic [MAX_LEN-1:0] DataOut;
  logic               Busy;
  logic               Done;
  logic               Err;
  logic [3:0]         TapState;

  modport slave (
    input  Start, IsIR, Length, DataIn, TDO,
    output TCK, TMS, TDI, DataOut,
    output Busy, Done, Err, TapState
  );

  modport master (
    output Start, IsIR, Length, DataIn, TDO,
    input  TCK, TMS, TDI, DataOut,
    input  Busy, Done, Err, TapState
  );

endinterface

// File: rtl/jtag_tap_tracker.sv
// Mirror of the target's 16-state TAP controller, advanced on each
// rising TCK with the TMS value being driven.
module jtag_tap_tracker
  import jtag_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       tck_rise,
  input  logic       tms,
  output logic [3:0] state
);

  logic [3:0] state_q, state_d;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= TAP_TLR;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      unique case (state_q)
        TAP_TLR:      state_d = tms ? TAP_TLR      : TAP_RTI;
        TAP_RTI:      state_d = tms ? TAP_SEL_DR   : TAP_RTI;
        TAP_SEL_DR:   state_d = tms ? TAP_SEL_IR   : TAP_CAP_DR;
        TAP_CAP_DR:   state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
        TAP_SHIFT_DR: state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
        TAP_EXIT1_DR: state_d = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
        TAP_PAUSE_DR: state_d = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
        TAP_EXIT2_DR: state_d = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
        TAP_UPD_DR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
        TAP_SEL_IR:   state_d = tms ? TAP_TLR      : TAP_CAP_IR;
        TAP_CAP_IR:   state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
        TAP_SHIFT_IR: state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
        TAP_EXIT1_IR: state_d = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
        TAP_PAUSE_IR: state_d = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
        TAP_EXIT2_IR: state_d = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
        TAP_UPD_IR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
        default:      state_d = TAP_TLR;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: rtl/jtag_tap_driver.sv
// JTAG host initiator: turns a parallel IR/DR scan request into the
// TCK/TMS/TDI sequence and returns the captured TDO bits in parallel.
module jtag_tap_driver
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int DIV     = 2,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input logic              Clock,
  input logic              Reset_n,
  jtag_tap_driver_if.slave bus
);

  localparam int CW = LEN_W + 3;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  ctl_e               st_q, st_d;
  logic [DW-1:0]      div_q, div_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               isir_q, isir_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] sh_q, sh_d;
  logic [MAX_LEN-1:0] mask_q, mask_d;
  logic [MAX_LEN-1:0] dout_q, dout_d;
  logic               ran_q, ran_d;
  logic               rej_q, rej_d;

  logic [3:0]    tap;
  logic          run, tick, rise, fall;
  logic          len_ok, in_shift;
  logic [CW-1:0] pre, shl, last, nxt;

  jtag_tap_tracker u_trk (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .tck_rise (rise),
    .tms      (tms_q),
    .state    (tap)
  );

  assign run  = (st_q == C_RST_SEQ) || (st_q == C_SCAN);
  assign tick = (div_q == DW'(DIV - 1));
  assign rise = run && tick && !tck_q;
  assign fall = run && tick && tck_q;

  assign len_ok   = (bus.Length != '0) &&
                    (bus.Length <= LEN_W'(MAX_LEN));
  assign in_shift = (tap == TAP_SHIFT_DR) ||
                    (tap == TAP_SHIFT_IR);

  // TCK indices: pre = first shift TCK, shl = last shift TCK
  assign pre  = isir_q ? CW'(4) : CW'(3);
  assign shl  = pre + CW'(len_q) - CW'(1);
  assign last = (st_q == C_RST_SEQ) ? CW'(RST_SEQ_LEN - 1)
                                    : shl + CW'(2);
  assign nxt  = cnt_q + CW'(1);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      st_q   <= C_RST_SEQ;
      div_q  <= '0;
      tck_q  <= 1'b0;
      tms_q  <= 1'b1;
      tdi_q  <= 1'b0;
      cnt_q  <= '0;
      isir_q <= 1'b0;
      len_q  <= '0;
      sh_q   <= '0;
      mask_q <= '0;
      dout_q <= '0;
      ran_q  <= 1'b0;
      rej_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      div_q  <= div_d;
      tck_q  <= tck_d;
      tms_q  <= tms_d;
      tdi_q  <= tdi_d;
      cnt_q  <= cnt_d;
      isir_q <= isir_d;
      len_q  <= len_d;
      sh_q   <= sh_d;
      mask_q <= mask_d;
      dout_q <= dout_d;
      ran_q  <= ran_d;
      rej_q  <= rej_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    div_d  = div_q;
    tck_d  = tck_q;
    tms_d  = tms_q;
    tdi_d  = tdi_q;
    cnt_d  = cnt_q;
    isir_d = isir_q;
    len_d  = len_q;
    sh_d   = sh_q;
    mask_d = mask_q;
    dout_d = dout_q;
    ran_d  = ran_q;
    rej_d  = 1'b0;

    if (run) begin
      if (tick) begin
        div_d = '0;
        tck_d = ~tck_q;
      end else begin
        div_d = div_q + DW'(1);
      end
    end

    // Tracker state is still the pre-edge one, so the exit edge counts
    if (rise && in_shift) begin
      dout_d = dout_q | (bus.TDO ? mask_q : '0);
      mask_d = mask_q << 1;
    end

    unique case (st_q)
      C_RST_SEQ: begin
        if (fall) begin
          cnt_d = nxt;
          tms_d = (nxt < CW'(RST_SEQ_LEN - 1));
          if (cnt_q == last) begin
            st_d  = C_FINISH;
            cnt_d = '0;
            tms_d = 1'b0;
          end
        end
      end
      C_IDLE: begin
        if (bus.Start) begin
          if (len_ok) begin
            st_d   = C_SCAN;
            isir_d = bus.IsIR;
            len_d  = bus.Length;
            sh_d   = bus.DataIn;
            dout_d = '0;
            mask_d = MAX_LEN'(1);
            cnt_d  = '0;
            div_d  = '0;
            tms_d  = 1'b1;
            tdi_d  = 1'b0;
            ran_d  = 1'b1;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      C_SCAN: begin
        if (fall) begin
          cnt_d = nxt;
          tms_d = (isir_q && (nxt == CW'(1))) ||
                  (nxt == shl) ||
                  (nxt == shl + CW'(1));
          tdi_d = 1'b0;
          if ((nxt >= pre) && (nxt <= shl)) begin
            tdi_d = sh_q[0];
            sh_d  = sh_q >> 1;
          end
          if (cnt_q == last) begin
            st_d  = C_FINISH;
            cnt_d = '0;
            tms_d = 1'b0;
            tdi_d = 1'b0;
          end
        end
      end
      C_FINISH: st_d = C_IDLE;
      default:  st_d = C_RST_SEQ;
    endcase
  end

  assign bus.TCK      = tck_q;
  assign bus.TMS      = tms_q;
  assign bus.TDI      = tdi_q;
  assign bus.DataOut  = dout_q;
  assign bus.Busy     = run;
  // The post-reset sequence also passes FINISH but reports nothing
  assign bus.Done     = ((st_q == C_FINISH) && ran_q) || rej_q;
  assign bus.Err      = rej_q;
  assign bus.TapState = tap;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Directed bench for jtag_tap_driver: 4-bit boundary-scan chain and
// 5-bit IR target model on the DIV=2 instance, plus DIV=1/3 instances.
module tb_jtag_tap_driver;
  import jtag_pkg::*;

  localparam int M_TLR = 0, M_RTI = 1, M_SDR = 2, M_CDR = 3;
  localparam int M_SHDR = 4, M_E1DR = 5, M_PDR = 6, M_E2DR = 7;
  localparam int M_UDR = 8, M_SIR = 9, M_CIR = 10, M_SHIR = 11;
  localparam int M_E1IR = 12, M_PIR = 13, M_E2IR = 14, M_UIR = 15;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 Clock = ~Clock;

  jtag_tap_driver_if #(.MAX_LEN(32)) bus ();
  jtag_tap_driver_if #(.MAX_LEN(32)) bus1 ();
  jtag_tap_driver_if #(.MAX_LEN(32)) bus3 ();

  jtag_tap_driver #(.MAX_LEN(32), .DIV(2)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .bus(bus));
  jtag_tap_driver #(.MAX_LEN(32), .DIV(1)) dut1 (
    .Clock(Clock), .Reset_n(Reset_n), .bus(bus1));
  jtag_tap_driver #(.MAX_LEN(32), .DIV(3)) dut3 (
    .Clock(Clock), .Reset_n(Reset_n), .bus(bus3));

  // target TAP model: next state for TMS=0 / TMS=1
  int nx0 [16] = '{M_RTI, M_RTI, M_CDR, M_SHDR, M_SHDR, M_PDR,
                   M_PDR, M_SHDR, M_RTI, M_CIR, M_SHIR, M_SHIR,
                   M_PIR, M_PIR, M_SHIR, M_RTI};
  int nx1 [16] = '{M_TLR, M_SDR, M_SIR, M_E1DR, M_E1DR, M_UDR,
                   M_E2DR, M_UDR, M_SDR, M_TLR, M_E1IR, M_E1IR,
                   M_UIR, M_E2IR, M_UIR, M_SDR};
  int ms = M_TLR;
  logic [3:0] pins = 4'h0;
  logic [3:0] chain = 4'h0;
  logic [4:0] irsh = 5'h0;
  logic [4:0] ir = 5'h0;
  logic tdo_m = 1'b0;

  assign bus.TDO  = tdo_m;
  assign bus1.TDO = 1'b1;
  assign bus3.TDO = 1'b1;

  int ntck = 0;
  logic [255:0] tms_log = '0;
  logic [255:0] tdi_log = '0;
  time tr [256];

  always @(posedge bus.TCK) begin
    if (ntck < 256) begin
      tms_log[ntck] = bus.TMS;
      tdi_log[ntck] = bus.TDI;
      tr[ntck] = $time;
    end
    ntck++;
    case (ms)
      M_CDR:  chain = pins;
      M_SHDR: chain = {bus.TDI, chain[3:1]};
      M_CIR:  irsh = 5'b00001;
      M_SHIR: irsh = {bus.TDI, irsh[4:1]};
      M_UIR:  ir = irsh;
      default: ;
    endcase
    ms = bus.TMS ? nx1[ms] : nx0[ms];
  end

  always @(negedge bus.TCK) begin
    if (ms == M_SHDR)      tdo_m = chain[0];
    else if (ms == M_SHIR) tdo_m = irsh[0];
    else                   tdo_m = 1'b0;
  end

  int done_cnt = 0;
  always @(negedge Clock) if (bus.Done === 1'b1) done_cnt++;

  int n1 = 0, n3 = 0;
  time t1 [64];
  time t3 [64];
  always @(posedge bus1.TCK) begin
    if (n1 < 64) t1[n1] = $time;
    n1++;
  end
  always @(posedge bus3.TCK) begin
    if (n3 < 64) t3[n3] = $time;
    n3++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy_low(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge Clock);
      if (bus.Busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge Clock);
      if (bus.Done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, db, b1, b3;
    bit ok;
    bus.Start = 0; bus.IsIR = 0; bus.Length = '0; bus.DataIn = '0;
    bus1.Start = 0; bus1.IsIR = 0; bus1.Length = '0; bus1.DataIn = '0;
    bus3.Start = 0; bus3.IsIR = 0; bus3.Length = '0; bus3.DataIn = '0;

    // reset state
    repeat (2) @(negedge Clock);
    chk("rst_tck", bus.TCK, 0);
    chk("rst_tms", bus.TMS, 1);
    chk("rst_tdi", bus.TDI, 0);
    chk("rst_dout", bus.DataOut, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_err", bus.Err, 0);
    chk("rst_tap", bus.TapState, TAP_TLR);
    chk("rst_busy", bus.Busy, 1);

    // post-reset TAP sequence
    b = ntck; db = done_cnt;
    Reset_n = 1'b1;
    wait_busy_low(200, ok);
    chk("rs_timeout", ok, 1);
    chk("rs_ntck", ntck - b, 6);
    chk("rs_tms", tms_log[b +: 6], 6'h1F);
    chk("rs_period", int'(tr[b + 1] - tr[b]), 40);
    chk("rs_tap", bus.TapState, TAP_RTI);
    chk("rs_nodone", done_cnt - db, 0);

    // Start in the cycle Busy falls is dropped
    bus.Start = 1; bus.IsIR = 0; bus.Length = 6'd4; bus.DataIn = 32'hB;
    @(negedge Clock);
    bus.Start = 0;
    @(negedge Clock);
    chk("fall_start_ign", bus.Busy, 0);

    // DR scan, 4 bits
    pins = 4'b0110;
    b = ntck; db = done_cnt;
    bus.Start = 1; bus.IsIR = 0; bus.Length = 6'd4; bus.DataIn = 32'hB;
    @(negedge Clock);
    bus.Start = 0;
    chk("dr_busy", bus.Busy, 1);
    wait_done(200, ok);
    chk("dr_timeout", ok, 1);
    chk("dr_err", bus.Err, 0);
    chk("dr_busy_fall", bus.Busy, 0);
    chk("dr_dout", bus.DataOut, 32'h6);
    chk("dr_tap", bus.TapState, TAP_RTI);
    @(negedge Clock);
    chk("dr_pulse", done_cnt - db, 1);
    chk("dr_ntck", ntck - b, 9);
    chk("dr_tms", tms_log[b +: 9], 9'h0C1);
    chk("dr_tdi", tdi_log[b +: 9], 9'h058);
    chk("dr_period", int'(tr[b + 1] - tr[b]), 40);
    chk("dr_chain", chain, 4'hB);

    // IR scan, started in the first idle cycle, Start pulsed mid-scan
    b = ntck;
    bus.Start = 1; bus.IsIR = 1; bus.Length = 6'd5; bus.DataIn = 32'h15;
    @(negedge Clock);
    bus.Start = 0;
    chk("ir_busy", bus.Busy, 1);
    repeat (20) @(negedge Clock);
    bus.Start = 1; bus.IsIR = 0; bus.Length = 6'd3; bus.DataIn = 32'h7;
    @(negedge Clock);
    bus.Start = 0;
    wait_done(300, ok);
    chk("ir_timeout", ok, 1);
    chk("ir_dout", bus.DataOut, 32'h1);
    chk("ir_ntck", ntck - b, 11);
    chk("ir_tms", tms_log[b +: 11], 11'h303);
    chk("ir_tdi", tdi_log[b +: 11], 11'h150);
    chk("ir_reg", ir, 5'h15);
    repeat (30) @(negedge Clock);
    chk("ign_busy", bus.Busy, 0);
    chk("ign_ntck", ntck - b, 11);
    chk("ign_dout", bus.DataOut, 32'h1);

    // rejected lengths 0 and 33
    b = ntck;
    bus.Start = 1; bus.Length = 6'd0; bus.DataIn = 32'hFFFF;
    @(negedge Clock);
    bus.Start = 0;
    chk("rj0_done", bus.Done, 1);
    chk("rj0_err", bus.Err, 1);
    chk("rj0_busy", bus.Busy, 0);
    @(negedge Clock);
    chk("rj0_pulse", bus.Done, 0);
    chk("rj0_dout", bus.DataOut, 32'h1);
    bus.Start = 1; bus.Length = 6'd33;
    @(negedge Clock);
    bus.Start = 0;
    chk("rj33_done", bus.Done, 1);
    chk("rj33_err", bus.Err, 1);
    chk("rj33_busy", bus.Busy, 0);
    @(negedge Clock);
    chk("rj33_pulse", bus.Err, 0);
    chk("rj33_dout", bus.DataOut, 32'h1);
    chk("rj_no_tck", ntck - b, 0);

    // reset during the 3rd shift TCK of a DR scan
    b = ntck; db = done_cnt;
    bus.Start = 1; bus.IsIR = 0; bus.Length = 6'd4; bus.DataIn = 32'hF;
    @(negedge Clock);
    bus.Start = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ntck - b >= 6) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clock);
    end
    chk("mr_reach", ok, 1);
    Reset_n = 1'b0;
    #1;
    chk("mr_tck", bus.TCK, 0);
    chk("mr_tms", bus.TMS, 1);
    chk("mr_busy", bus.Busy, 1);
    chk("mr_tap", bus.TapState, TAP_TLR);
    chk("mr_dout", bus.DataOut, 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    b = ntck;
    wait_busy_low(200, ok);
    chk("mr_timeout", ok, 1);
    chk("mr_nodone", done_cnt - db, 0);
    chk("mr_ntck", ntck - b, 6);
    chk("mr_seq", tms_log[b +: 6], 6'h1F);

    // DIV=1 and DIV=3, DR length 1
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (bus1.Busy === 1'b0 && bus3.Busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("dv_ready", ok, 1);
    @(negedge Clock);
    b1 = n1; b3 = n3;
    bus1.Start = 1; bus1.IsIR = 0; bus1.Length = 6'd1; bus1.DataIn = 0;
    bus3.Start = 1; bus3.IsIR = 0; bus3.Length = 6'd1; bus3.DataIn = 0;
    @(negedge Clock);
    bus1.Start = 0; bus3.Start = 0;
    chk("d1_busy", bus1.Busy, 1);
    chk("d3_busy", bus3.Busy, 1);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clock);
      if (bus1.Busy === 1'b0 && bus3.Busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("dv_timeout", ok, 1);
    chk("d1_ntck", n1 - b1, 6);
    chk("d3_ntck", n3 - b3, 6);
    chk("d1_period", int'(t1[b1 + 1] - t1[b1]), 20);
    chk("d3_period", int'(t3[b3 + 1] - t3[b3]), 60);
    chk("d1_dout", bus1.DataOut, 32'h1);
    chk("d3_dout", bus3.DataOut, 32'h1);
    chk("d3_tap", bus3.TapState, TAP_RTI);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
